sprite_line_fetcher: RTL
========================

Name: sprite_line_fetcher

Overview:
- Upstream of the Sprites pixel output stage.
- Consumes row/column from the VGA timing counter and drives the 2-bit sprite pixel that the output stage maps to RGB.
- During horizontal blanking it evaluates and prefetches the pattern rows of up to NUM_SPRITES 16x16 2bpp sprites for the next line.
- During active video it shifts those rows out against the current column.

Parameters:
- NUM_SPRITES, 4: sprite attribute slots; lowest index has highest priority.
- H_ACTIVE, 640: first blanking column; prefetch trigger.
- V_TOTAL, 525: rows per frame; next-row wrap point.
- H_OFFSET, 16: screen column of playfield x=0.
- PF_SIZE, 256: playfield width and height in pixels.

Ports:
- i_Clk, in, 1: pixel clock.
- i_Rst_L, in, 1: asynchronous active-low reset.
- i_Row, in, 10: current VGA row.
- i_Column, in, 10: current VGA column.
- i_Attr_We, in, 1: attribute write strobe.
- i_Attr_Addr, in, 2: sprite slot.
- i_Attr_Data, in, 21: {enable, y[7:0], x[7:0], tile[3:0]}.
- o_Rom_Addr, out, 8: {tile[3:0], line[3:0]}; one 32-bit pattern row per address.
- i_Rom_Data, in, 32: pattern row, valid 1 cycle after o_Rom_Addr. Bits [31:30] are the leftmost pixel.
- o_Pixel, out, 2: sprite colour index; 0 means transparent.
- o_Sprite_Hit, out, 1: o_Pixel is non-zero.
- o_Busy, out, 1: prefetch in progress.

Behaviour:
- Reset values: all outputs 0. FSM is IDLE. Line buffers, shift counters and the attribute table are cleared (all sprites disabled).
- Attribute writes take effect on the clock edge after i_Attr_We, in any state.
- next_row = i_Row+1, or 0 when i_Row == V_TOTAL-1.
- Prefetch FSM has six states: IDLE, EVAL, ADDR, WAIT, LOAD, DONE.
  - IDLE -> EVAL when i_Column == H_ACTIVE. Slot index s=0. Every slot's line buffer is cleared.
  - EVAL: latch slot s attributes. If enabled and (next_row - y) in 0..15 (unsigned 10-bit, next_row < PF_SIZE), go to ADDR. Otherwise the slot is marked empty and the FSM goes to the next slot, or to DONE after the last slot.
  - ADDR: drive o_Rom_Addr={tile, next_row-y}, then go to WAIT.
  - WAIT: one cycle of ROM latency.
  - LOAD: capture i_Rom_Data into the slot s line buffer, store x, advance s, return to EVAL. After the last slot, go to DONE.
  - DONE -> IDLE when i_Column == 0.
- Worst case is 4 cycles per slot, 16 cycles total, inside the 160-cycle blank.
- o_Busy is high in every state except IDLE and DONE.
- Attributes are sampled only in EVAL. A write to an already-evaluated slot affects the next line only.
- Active output, per slot, when i_Column == H_OFFSET+x:
  - The slot starts emitting; buffer bits [31:30] are shifted out, 2 bits per clock, for 16 clocks.
  - Slot pixel is 0 when the slot is not emitting.
  - x+16 beyond the playfield edge (PF_SIZE) is clipped: no pixel is emitted at or past column H_OFFSET+PF_SIZE.
- o_Pixel is the lowest-index non-zero slot pixel, registered with 1 cycle latency relative to i_Column. o_Sprite_Hit is registered the same way.
- Outside the playfield window (row >= PF_SIZE or column outside H_OFFSET..H_OFFSET+PF_SIZE-1), o_Pixel=0.
- A sprite hitting row 255 shows only its visible lines. Row 524 prefetches for row 0.
- Reset mid-prefetch aborts immediately. Partially loaded buffers are cleared and nothing is displayed until the next full prefetch.

Optional Feature:
- Macro SPRITE_COLLISION_EN.
- Defined: adds output o_Collision (1 bit). It sets sticky when two or more slots emit non-zero pixels on the same clock. It clears on the clock where i_Row==0 and i_Column==0, and on reset.
- Not defined: no port and no logic.

Decomposition:
- Package sprite_pkg: attribute field widths and bit positions, SPRITE_W=16, BPP=2, FSM state encoding, default timing constants.
- One sub-module, sprite_slot_shifter: per-slot line buffer, x compare, 16-pixel shift counter, clip. Instantiated NUM_SPRITES times.
- The FSM and priority mux stay in the top.

Test Plan:
- Reset held low during active line, released at column 100 -> o_Pixel=0, o_Busy=0 until the next H_ACTIVE.
- Slot0 {en=1,y=10,x=0,tile=3}, ROM row(3,0)=0x40000000, i_Row=9 -> o_Rom_Addr=0x30 during prefetch. On row 10, o_Pixel=1 on the clock after column 16 only.
- Slot0 and slot1 both at x=20,y=0, slot0 row=0xFFFFFFFF, slot1 row=0xAAAAAAAA -> o_Pixel=3 for columns 36..51. With the macro, o_Collision=1 and it clears at frame start.
- Slot2 x=250 with row 0xFFFFFFFF -> o_Pixel=3 for columns 266..271 and 0 from column 272.
- i_Row=524 with a sprite at y=0 -> the fetch for row 0 occurs and the sprite line appears on row 0.
- Sprite at y=250 -> visible on rows 250..255, with no ROM fetch on rows 256+.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite line fetcher: attribute layout, pattern
// row geometry, prefetch FSM encoding and default VGA/playfield timing.
package sprite_pkg;

    localparam int SPRITE_W = 16;
    localparam int BPP      = 2;
    localparam int ROW_BITS = SPRITE_W * BPP;

    localparam int ATTR_W        = 21;
    localparam int ATTR_EN_BIT   = 20;
    localparam int ATTR_Y_LSB    = 12;
    localparam int ATTR_X_LSB    = 4;
    localparam int ATTR_TILE_LSB = 0;
    localparam int COORD_W       = 8;
    localparam int TILE_W        = 4;
    localparam int LINE_W        = 4;
    localparam int SLOT_W        = 2;
    localparam int SCREEN_W      = 10;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_TOTAL  = 525;
    localparam int DEF_H_OFFSET = 16;
    localparam int DEF_PF_SIZE  = 256;

    // Bit order matches the write bus {enable, y, x, tile}.
    typedef struct packed {
        logic               en;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] x;
        logic [TILE_W-1:0]  tile;
    } sprite_attr_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EVAL,
        ST_ADDR,
        ST_WAIT,
        ST_LOAD,
        ST_DONE
    } fetch_state_e;

endpackage

// File: rtl/sprite_slot_shifter.sv
// One sprite slot: holds the prefetched 16-pixel pattern row and shifts it out,
// 2 bits per clock, starting at the slot's screen column, clipped at the playfield edge.
module sprite_slot_shifter
    import sprite_pkg::*;
#(
    parameter int H_OFFSET = DEF_H_OFFSET,
    parameter int PF_SIZE  = DEF_PF_SIZE
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                load_i,
    input  logic [ROW_BITS-1:0] data_i,
    input  logic [COORD_W-1:0]  x_i,
    input  logic [SCREEN_W-1:0] column_i,
    output logic [BPP-1:0]      pixel_o
);

    localparam logic [SCREEN_W-1:0] COL_FIRST_C = SCREEN_W'(H_OFFSET);
    localparam logic [SCREEN_W-1:0] COL_END_C   = SCREEN_W'(H_OFFSET + PF_SIZE);

    logic [ROW_BITS-1:0] sh_q, sh_d;
    logic [COORD_W-1:0]  x_q, x_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                start, emitting, clipped;

    assign start    = (column_i == COL_FIRST_C + {2'b00, x_q});
    assign emitting = start || (cnt_q != 4'd0);
    assign clipped  = (column_i >= COL_END_C);
    assign pixel_o  = (emitting && !clipped) ? sh_q[ROW_BITS-1 -: BPP] : '0;

    // The row is consumed as it is shown; a fresh prefetch reloads it every line.
    always_comb begin
        sh_d  = sh_q;
        x_d   = x_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            sh_d  = '0;
            x_d   = '0;
            cnt_d = '0;
        end else if (load_i) begin
            sh_d  = data_i;
            x_d   = x_i;
            cnt_d = '0;
        end else if (start) begin
            sh_d  = {sh_q[ROW_BITS-BPP-1:0], {BPP{1'b0}}};
            cnt_d = 4'(SPRITE_W - 1);
        end else if (cnt_q != 4'd0) begin
            sh_d  = {sh_q[ROW_BITS-BPP-1:0], {BPP{1'b0}}};
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sh_q  <= '0;
            x_q   <= '0;
            cnt_q <= '0;
        end else begin
            sh_q  <= sh_d;
            x_q   <= x_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sprite_line_fetcher.sv
// Prefetches up to NUM_SPRITES sprite pattern rows during horizontal blanking and
// mixes their pixels by slot priority during active video. SPRITE_COLLISION_EN adds o_Collision.
module sprite_line_fetcher
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES = 4,
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int V_TOTAL     = DEF_V_TOTAL,
    parameter int H_OFFSET    = DEF_H_OFFSET,
    parameter int PF_SIZE     = DEF_PF_SIZE
) (
    input  logic                i_Clk,
    input  logic                i_Rst_L,
    input  logic [SCREEN_W-1:0] i_Row,
    input  logic [SCREEN_W-1:0] i_Column,
    input  logic                i_Attr_We,
    input  logic [SLOT_W-1:0]   i_Attr_Addr,
    input  logic [ATTR_W-1:0]   i_Attr_Data,
    output logic [7:0]          o_Rom_Addr,
    input  logic [ROW_BITS-1:0] i_Rom_Data,
    output logic [BPP-1:0]      o_Pixel,
    output logic                o_Sprite_Hit,
    output logic                o_Busy
`ifdef SPRITE_COLLISION_EN
    ,
    output logic                o_Collision
`endif
);

    localparam logic [SCREEN_W-1:0] H_ACTIVE_C  = SCREEN_W'(H_ACTIVE);
    localparam logic [SCREEN_W-1:0] V_LAST_C    = SCREEN_W'(V_TOTAL - 1);
    localparam logic [SCREEN_W-1:0] PF_SIZE_C   = SCREEN_W'(PF_SIZE);
    localparam logic [SCREEN_W-1:0] COL_FIRST_C = SCREEN_W'(H_OFFSET);
    localparam logic [SCREEN_W-1:0] COL_END_C   = SCREEN_W'(H_OFFSET + PF_SIZE);
    localparam logic [SLOT_W-1:0]   LAST_SLOT_C = SLOT_W'(NUM_SPRITES - 1);

    sprite_attr_t          attr_q [NUM_SPRITES];
    fetch_state_e          state_q, state_d;
    logic [SLOT_W-1:0]     slot_q, slot_d;
    logic [COORD_W-1:0]    cur_x_q, cur_x_d;
    logic [7:0]            rom_addr_q, rom_addr_d;
    logic [BPP-1:0]        pixel_q, pixel_d, px_sel;
    logic                  hit_q;
    logic                  clear_all, in_window, fetch_hit, last_slot;
    logic [NUM_SPRITES-1:0] load_vec;
    logic [SCREEN_W-1:0]   next_row, line_diff;
    sprite_attr_t          cur_attr;
    logic [BPP-1:0]        slot_px [NUM_SPRITES];

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            for (int i = 0; i < NUM_SPRITES; i++) attr_q[i] <= '0;
        end else if (i_Attr_We) begin
            attr_q[i_Attr_Addr] <= sprite_attr_t'(i_Attr_Data);
        end
    end

    // Unsigned wrap of next_row - y rejects sprites below the next line too.
    assign next_row  = (i_Row == V_LAST_C) ? '0 : i_Row + 10'd1;
    assign cur_attr  = attr_q[slot_q];
    assign line_diff = next_row - {2'b00, cur_attr.y};
    assign fetch_hit = cur_attr.en && (next_row < PF_SIZE_C) && (line_diff < 10'd16);
    assign last_slot = (slot_q == LAST_SLOT_C);

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        cur_x_d    = cur_x_q;
        rom_addr_d = rom_addr_q;
        clear_all  = 1'b0;
        load_vec   = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_Column == H_ACTIVE_C) begin
                    state_d   = ST_EVAL;
                    slot_d    = '0;
                    clear_all = 1'b1;
                end
            end
            ST_EVAL: begin
                cur_x_d = cur_attr.x;
                if (fetch_hit) begin
                    rom_addr_d = {cur_attr.tile, line_diff[LINE_W-1:0]};
                    state_d    = ST_ADDR;
                end else if (last_slot) begin
                    state_d = ST_DONE;
                end else begin
                    slot_d = slot_q + 2'd1;
                end
            end
            ST_ADDR: state_d = ST_WAIT;
            ST_WAIT: state_d = ST_LOAD;
            ST_LOAD: begin
                load_vec[slot_q] = 1'b1;
                if (last_slot) begin
                    state_d = ST_DONE;
                end else begin
                    slot_d  = slot_q + 2'd1;
                    state_d = ST_EVAL;
                end
            end
            ST_DONE: begin
                if (i_Column == '0) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    genvar g;
    generate
        for (g = 0; g < NUM_SPRITES; g++) begin : g_slot
            sprite_slot_shifter #(
                .H_OFFSET (H_OFFSET),
                .PF_SIZE  (PF_SIZE)
            ) u_slot (
                .clk_i    (i_Clk),
                .rst_ni   (i_Rst_L),
                .clear_i  (clear_all),
                .load_i   (load_vec[g]),
                .data_i   (i_Rom_Data),
                .x_i      (cur_x_q),
                .column_i (i_Column),
                .pixel_o  (slot_px[g])
            );
        end
    endgenerate

    // Scanning from the highest index down leaves the lowest non-zero slot on top.
    always_comb begin
        px_sel = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (slot_px[i] != '0) px_sel = slot_px[i];
        end
        in_window = (i_Row < PF_SIZE_C) && (i_Column >= COL_FIRST_C) && (i_Column < COL_END_C);
        pixel_d   = in_window ? px_sel : '0;
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q    <= ST_IDLE;
            slot_q     <= '0;
            cur_x_q    <= '0;
            rom_addr_q <= '0;
            pixel_q    <= '0;
            hit_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            cur_x_q    <= cur_x_d;
            rom_addr_q <= rom_addr_d;
            pixel_q    <= pixel_d;
            hit_q      <= (pixel_d != '0);
        end
    end

    assign o_Rom_Addr   = rom_addr_q;
    assign o_Pixel      = pixel_q;
    assign o_Sprite_Hit = hit_q;
    assign o_Busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);

`ifdef SPRITE_COLLISION_EN
    logic [2:0] nz_cnt;
    logic       coll_q;

    always_comb begin
        nz_cnt = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (slot_px[i] != '0) nz_cnt = nz_cnt + 3'd1;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            coll_q <= 1'b0;
        end else if ((i_Row == '0) && (i_Column == '0)) begin
            coll_q <= 1'b0;
        end else if (in_window && (nz_cnt >= 3'd2)) begin
            coll_q <= 1'b1;
        end
    end

    assign o_Collision = coll_q;
`endif

endmodule
